// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types and defaults for the unified-memory port arbiter.
//   arb_state_e   : arbiter FSM states (IDLE, IF_ACC, DM_ACC)
//   mem_acc_t     : access descriptor presented to the memory {we, addr, wdata}
//   DEF_*         : default parameter values for the arbiter and its watchdog
//   make_fetch    : builds the descriptor for an instruction fetch
//   make_data     : builds the descriptor for a load/store
// -----------------------------------------------------------------------------
package mips_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_ACC = 2'd1,
      DM_ACC = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_acc_t;

   localparam int DEF_MAX_DM_STREAK = 4;
   localparam int DEF_TIMEOUT       = 64;
   localparam int DEF_CNT_W         = 7;

   // Fetches never write; wdata is parked at zero so the bus is quiet.
   function automatic mem_acc_t make_fetch(input logic [31:0] addr);
      mem_acc_t acc;
      acc.we    = 1'b0;
      acc.addr  = addr;
      acc.wdata = 32'h0;
      return acc;
   endfunction

   function automatic mem_acc_t make_data(input logic        we,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata);
      mem_acc_t acc;
      acc.we    = we;
      acc.addr  = addr;
      acc.wdata = wdata;
      return acc;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the pipeline-side and memory-side signals of the arbiter.
//   Fetch  : if_req, if_addr -> if_rdata, if_ack
//   Data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ack
//   Status : acc_err (qualifies the acks), stall_if, stall_mem
//   Memory : mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ready
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (pipeline stages + memory)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   logic        acc_err;
   logic        stall_if;
   logic        stall_mem;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, acc_err, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, acc_err, stall_if, stall_mem,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// mem_arb_watchdog
// Counts the cycles an access has spent waiting for the memory.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : hold the count at zero (no access in flight)
//   en       : a waited cycle (access in flight, memory not ready)
//   expire   : this waited cycle is the last one allowed
// -----------------------------------------------------------------------------
module mem_arb_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 7
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Gated by en so a ready memory on the final cycle completes normally.
   assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the memory
// stage. Data accesses win ties until MAX_DM_STREAK consecutive data grants
// have been made against a waiting fetch; then the fetch goes next. Each
// access is held on the memory bus until mem_ready or a watchdog timeout,
// then acknowledged with a one-cycle pulse (acc_err=1 on timeout).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (pipeline requests, acks, read data,
//              stalls, and the memory request/ready handshake)
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
   parameter int TIMEOUT       = DEF_TIMEOUT,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);

   localparam int                  STREAK_W   = $clog2(MAX_DM_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

   arb_state_e          state_q, state_d;
   mem_acc_t            acc_q, acc_d;
   logic                mem_req_q, mem_req_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic                acc_err_q, acc_err_d;
   logic [31:0]         if_rdata_q, if_rdata_d;
   logic [31:0]         dm_rdata_q, dm_rdata_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   logic if_pend;
   logic dm_pend;
   logic turnaround;
   logic in_access;
   logic wd_expire;
   logic finish_acc;

   // A requester still sees its ack this cycle; its held req is not new.
   assign if_pend    = bus.if_req && !if_ack_q;
   assign dm_pend    = bus.dm_req && !dm_ack_q;
   // The cycle carrying an ack is the idle turnaround: no grant is made.
   assign turnaround = if_ack_q || dm_ack_q;
   assign in_access  = (state_q != IDLE);
   assign finish_acc = bus.mem_ready || wd_expire;

   mem_arb_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (!in_access),
      .en     (in_access && !bus.mem_ready),
      .expire (wd_expire)
   );

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      mem_req_d  = mem_req_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      acc_err_d  = 1'b0;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      streak_d   = streak_q;

      case (state_q)
         IDLE: begin
            if (!turnaround) begin
               if (dm_pend && (!if_pend || streak_q != STREAK_MAX)) begin
                  state_d   = DM_ACC;
                  mem_req_d = 1'b1;
                  acc_d     = make_data(bus.dm_we, bus.dm_addr, bus.dm_wdata);
                  // Only grants that make a fetch wait count toward the streak.
                  if (if_pend) begin
                     if (streak_q != STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                     end
                  end else begin
                     streak_d = '0;
                  end
               end else if (if_pend) begin
                  state_d   = IF_ACC;
                  mem_req_d = 1'b1;
                  acc_d     = make_fetch(bus.if_addr);
                  streak_d  = '0;
               end
            end
         end

         IF_ACC, DM_ACC: begin
            if (finish_acc) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               acc_d.we  = 1'b0;
               // mem_ready takes precedence over a coincident timeout.
               acc_err_d = !bus.mem_ready;
               if (state_q == IF_ACC) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'h0;
               end else begin
                  dm_ack_d = 1'b1;
                  if (!acc_q.we) begin
                     dm_rdata_d = bus.mem_ready ? bus.mem_rdata : 32'h0;
                  end
               end
            end
         end

         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         mem_req_q  <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         acc_err_q  <= 1'b0;
         if_rdata_q <= 32'h0;
         dm_rdata_q <= 32'h0;
         streak_q   <= '0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         mem_req_q  <= mem_req_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         acc_err_q  <= acc_err_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         streak_q   <= streak_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = acc_q.we;
   assign bus.mem_addr  = acc_q.addr;
   assign bus.mem_wdata = acc_q.wdata;
   assign bus.if_ack    = if_ack_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.acc_err   = acc_err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.stall_if  = bus.if_req && !if_ack_q;
   assign bus.stall_mem = bus.dm_req && !dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   int          mem_wait;
   logic [31:0] mem_data;
   int          wcnt;

   mem_port_arbiter_if bus();

   mem_port_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: ready after mem_wait waited cycles of a held request.
   always @(posedge clk) begin
      if (!bus.mem_req || bus.mem_ready) wcnt <= 0;
      else                               wcnt <= wcnt + 1;
   end
   assign bus.mem_ready = bus.mem_req && (wcnt == mem_wait);
   assign bus.mem_rdata = bus.mem_req ? mem_data : 32'h0;

   // Stimulus helper: waits (bounded) for an ack; cycle 0 is the request cycle.
   task automatic wait_ack(output int ack_cyc, output int hi_cyc);
      ack_cyc = -1;
      hi_cyc  = 0;
      for (int c = 0; c < 120; c++) begin
         @(negedge clk);
         if (bus.if_ack || bus.dm_ack) begin
            ack_cyc = c;
            break;
         end
         if (bus.mem_req) hi_cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      n_checks++; if ({bus.if_ack, bus.dm_ack, bus.acc_err} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b want 000", {bus.if_ack, bus.dm_ack, bus.acc_err}); end
      n_checks++; if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
      n_checks++; if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.dm_rdata}); end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_single_fetch();
      mem_wait = 0; mem_data = 32'h8C820004;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 32'h00400000;
      @(negedge clk); // cycle 0
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_mem_req: got %b want 0", bus.mem_req); end
      n_checks++; if (bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_c0_stall_if: got %b want 1", bus.stall_if); end
      @(negedge clk); // cycle 1
      n_checks++; if ({bus.mem_req, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL fetch_c1_req_we: got %b want 10", {bus.mem_req, bus.mem_we}); end
      n_checks++; if (bus.mem_addr !== 32'h00400000) begin n_fail++; $display("FAIL fetch_c1_addr: got %h want 00400000", bus.mem_addr); end
      n_checks++; if (bus.stall_if !== 1'b1) begin n_fail++; $display("FAIL fetch_c1_stall_if: got %b want 1", bus.stall_if); end
      @(negedge clk); // cycle 2
      n_checks++; if ({bus.if_ack, bus.acc_err, bus.stall_if, bus.mem_req} !== 4'b1000) begin n_fail++; $display("FAIL fetch_c2_ack_err_stall_req: got %b want 1000", {bus.if_ack, bus.acc_err, bus.stall_if, bus.mem_req}); end
      n_checks++; if (bus.if_rdata !== 32'h8C820004) begin n_fail++; $display("FAIL fetch_c2_rdata: got %h want 8c820004", bus.if_rdata); end
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      @(negedge clk);
      n_checks++; if (bus.if_ack !== 1'b0) begin n_fail++; $display("FAIL fetch_ack_pulse: got %b want 0", bus.if_ack); end
      $display("fetch 00400000 -> %h", bus.if_rdata);
   endtask

   task automatic test_store_then_fetch();
      mem_wait = 0; mem_data = 32'h12345678;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 32'h00400004;
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h10010000; bus.dm_wdata = 32'hDEADBEEF;
      @(negedge clk); // cycle 0
      @(negedge clk); // cycle 1
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.stall_mem} !== 3'b111) begin n_fail++; $display("FAIL st_c1_req_we_stall: got %b want 111", {bus.mem_req, bus.mem_we, bus.stall_mem}); end
      n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== {32'h10010000, 32'hDEADBEEF}) begin n_fail++; $display("FAIL st_c1_addr_wdata: got %h want 10010000deadbeef", {bus.mem_addr, bus.mem_wdata}); end
      @(negedge clk); // cycle 2
      n_checks++; if ({bus.dm_ack, bus.if_ack, bus.acc_err, bus.stall_mem, bus.stall_if} !== 5'b10001) begin n_fail++; $display("FAIL st_c2_acks_stalls: got %b want 10001", {bus.dm_ack, bus.if_ack, bus.acc_err, bus.stall_mem, bus.stall_if}); end
      n_checks++; if (bus.dm_rdata !== 32'h0) begin n_fail++; $display("FAIL st_c2_dm_rdata_kept: got %h want 0", bus.dm_rdata); end
      @(posedge clk); #1;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0;
      @(negedge clk); // cycle 3
      n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL st_c3_turnaround: got %b want 0", bus.mem_req); end
      @(negedge clk); // cycle 4
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h00400004}) begin n_fail++; $display("FAIL st_c4_fetch_grant: got %h want 2_00400004", {bus.mem_req, bus.mem_we, bus.mem_addr}); end
      @(negedge clk); // cycle 5
      n_checks++; if ({bus.if_ack, bus.acc_err, bus.if_rdata} !== {2'b10, 32'h12345678}) begin n_fail++; $display("FAIL st_c5_if_ack_rdata: got %h want 2_12345678", {bus.if_ack, bus.acc_err, bus.if_rdata}); end
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      $display("store 10010000 <- deadbeef, then fetch 00400004 -> %h", bus.if_rdata);
   endtask

   task automatic test_streak();
      logic grant_if [10];
      int   ng;
      logic prev;
      mem_wait = 0; mem_data = 32'h11112222;
      @(posedge clk); #1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10010040;
      bus.if_req = 1'b1; bus.if_addr = 32'h00400008;
      ng = 0; prev = 1'b0;
      for (int c = 0; c < 40 && ng < 10; c++) begin
         @(negedge clk);
         if (bus.mem_req && !prev) begin
            grant_if[ng] = (bus.mem_addr == 32'h00400008);
            ng++;
         end
         prev = bus.mem_req;
      end
      n_checks++; if (ng !== 10) begin n_fail++; $display("FAIL streak_grant_count: got %0d want 10", ng); end
      for (int i = 0; i < ng; i++) begin
         n_checks++;
         if (grant_if[i] !== (i % 5 == 4)) begin n_fail++; $display("FAIL streak_grant%0d_is_if: got %b want %b", i, grant_if[i], (i % 5 == 4)); end
      end
      @(negedge clk);
      n_checks++; if (bus.if_ack !== 1'b1) begin n_fail++; $display("FAIL streak_last_if_ack: got %b want 1", bus.if_ack); end
      @(posedge clk); #1;
      bus.dm_req = 1'b0; bus.if_req = 1'b0;
      $display("streak: %0d grants observed", ng);
   endtask

   task automatic test_timeout();
      int ack_cyc, hi_cyc;
      mem_wait = 200; mem_data = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10010080;
      wait_ack(ack_cyc, hi_cyc);
      n_checks++; if (ack_cyc !== 65) begin n_fail++; $display("FAIL to_ack_cycle: got %0d want 65", ack_cyc); end
      n_checks++; if (hi_cyc !== 64) begin n_fail++; $display("FAIL to_req_cycles: got %0d want 64", hi_cyc); end
      n_checks++; if ({bus.dm_ack, bus.if_ack, bus.acc_err, bus.mem_req} !== 4'b1010) begin n_fail++; $display("FAIL to_ack_err: got %b want 1010", {bus.dm_ack, bus.if_ack, bus.acc_err, bus.mem_req}); end
      n_checks++; if (bus.dm_rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata_zero: got %h want 0", bus.dm_rdata); end
      @(posedge clk); #1;
      bus.dm_req = 1'b0;
      @(negedge clk);
      n_checks++; if ({bus.dm_ack, bus.acc_err} !== 2'b00) begin n_fail++; $display("FAIL to_err_pulse: got %b want 00", {bus.dm_ack, bus.acc_err}); end
      $display("load 10010080 timed out at cycle %0d", ack_cyc);
      mem_wait = 0; mem_data = 32'h55AA0FF0;
      @(posedge clk); #1;
      bus.dm_req = 1'b1; bus.dm_addr = 32'h10010084;
      wait_ack(ack_cyc, hi_cyc);
      n_checks++; if (ack_cyc !== 2) begin n_fail++; $display("FAIL to_recover_cycle: got %0d want 2", ack_cyc); end
      n_checks++; if ({bus.dm_ack, bus.acc_err, bus.dm_rdata} !== {2'b10, 32'h55AA0FF0}) begin n_fail++; $display("FAIL to_recover_data: got %h want 2_55aa0ff0", {bus.dm_ack, bus.acc_err, bus.dm_rdata}); end
      @(posedge clk); #1;
      bus.dm_req = 1'b0;
      $display("load 10010084 -> %h", bus.dm_rdata);
   endtask

   task automatic test_ready_at_expiry();
      int ack_cyc, hi_cyc;
      mem_wait = 63; mem_data = 32'h0BADC0DE;
      @(posedge clk); #1;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h10010088;
      wait_ack(ack_cyc, hi_cyc);
      n_checks++; if (ack_cyc !== 65) begin n_fail++; $display("FAIL edge_ack_cycle: got %0d want 65", ack_cyc); end
      n_checks++; if ({bus.dm_ack, bus.acc_err, bus.dm_rdata} !== {2'b10, 32'h0BADC0DE}) begin n_fail++; $display("FAIL edge_ready_wins: got %h want 2_0badc0de", {bus.dm_ack, bus.acc_err, bus.dm_rdata}); end
      @(posedge clk); #1;
      bus.dm_req = 1'b0;
      $display("load 10010088 -> %h at cycle %0d", bus.dm_rdata, ack_cyc);
   endtask

   task automatic test_reset_mid_access();
      int ack_cyc, hi_cyc, late_acks, late_reqs;
      mem_wait = 10; mem_data = 32'h24020001;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 32'h00400100;
      repeat (3) @(negedge clk);
      @(posedge clk); #1; // cycle 3
      n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_in_flight: got %b want 1", bus.mem_req); end
      #2 rst = 1'b1;
      #1;
      n_checks++; if ({bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.acc_err} !== 5'b0) begin n_fail++; $display("FAIL rmid_ctrl_zero: got %b want 00000", {bus.mem_req, bus.mem_we, bus.if_ack, bus.dm_ack, bus.acc_err}); end
      n_checks++; if ({bus.mem_addr, bus.if_rdata, bus.dm_rdata} !== 96'h0) begin n_fail++; $display("FAIL rmid_data_zero: got %h want 0", {bus.mem_addr, bus.if_rdata, bus.dm_rdata}); end
      bus.if_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      late_acks = 0; late_reqs = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus.if_ack || bus.dm_ack) late_acks++;
         if (bus.mem_req) late_reqs++;
      end
      n_checks++; if ({late_acks, late_reqs} !== 64'h0) begin n_fail++; $display("FAIL rmid_no_late_ack: got acks=%0d reqs=%0d want 0/0", late_acks, late_reqs); end
      mem_wait = 0;
      @(posedge clk); #1;
      bus.if_req = 1'b1; bus.if_addr = 32'h00400104;
      wait_ack(ack_cyc, hi_cyc);
      n_checks++; if (ack_cyc !== 2) begin n_fail++; $display("FAIL rmid_fresh_cycle: got %0d want 2", ack_cyc); end
      n_checks++; if ({bus.if_ack, bus.acc_err, bus.if_rdata} !== {2'b10, 32'h24020001}) begin n_fail++; $display("FAIL rmid_fresh_data: got %h want 2_24020001", {bus.if_ack, bus.acc_err, bus.if_rdata}); end
      @(posedge clk); #1;
      bus.if_req = 1'b0;
      $display("fetch 00400104 after reset -> %h", bus.if_rdata);
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      mem_wait = 0; mem_data = 32'h0;
      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'h0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
      test_reset();
      test_single_fetch();
      test_store_then_fetch();
      test_streak();
      test_timeout();
      test_ready_at_expiry();
      test_reset_mid_access();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got hang want completion");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch stage and the memory stage of the 5-stage MIPS pipeline.
- Arbitrates requests and sequences each access through a request/ready handshake with the memory.
- Returns read data with a one-cycle ack pulse.
- Generates stall signals for the pipeline hazard logic.
- Enforces a starvation bound on fetch and a watchdog timeout on the memory.

Parameters:
- MAX_DM_STREAK, 4: maximum consecutive data grants while a fetch request is pending.
- TIMEOUT, 64: cycles an access may wait for mem_ready before it is aborted.
- CNT_W, 7: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  32  fetch byte address, word aligned
- if_rdata  out  32  fetched instruction
- if_ack  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data
- dm_ack  out  1  one-cycle completion pulse for data
- acc_err  out  1  qualifies if_ack/dm_ack: the access timed out
- stall_if  out  1  if_req & ~if_ack, fed to hold_pc/hold_if
- stall_mem  out  1  dm_req & ~dm_ack
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state = IDLE.
  - mem_req, mem_we, if_ack, dm_ack, acc_err = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
  - Streak and timeout counters = 0.
  - Reset mid-access abandons the access; no ack is issued.
- FSM states: IDLE, IF_ACC, DM_ACC.
- IDLE:
  - A requester whose ack is high this cycle is ignored, so a held req cannot be serviced twice.
  - Only dm_req pending: go to DM_ACC.
  - Only if_req pending: go to IF_ACC.
  - Both pending: choose DM_ACC unless streak == MAX_DM_STREAK, then choose IF_ACC.
  - On entry to an access state, mem_req=1 and mem_addr/mem_we/mem_wdata are registered from the winner. mem_we=0 for fetch.
  - Request sampled in IDLE at edge N gives mem_req high from cycle N+1.
- IF_ACC / DM_ACC:
  - mem_req and all mem_* outputs stay stable until completion.
  - The timeout counter increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata into if_rdata or dm_rdata (dm_rdata unchanged on stores). Pulse the matching ack for one cycle with acc_err=0. Drop mem_req. Return to IDLE.
  - Counter reaches TIMEOUT-1 with mem_ready=0: abort. Drop mem_req, load rdata = 0, pulse ack with acc_err=1, return to IDLE.
  - mem_ready and timeout in the same cycle: mem_ready wins.
- Minimum access latency: request → ack = 2 cycles with a zero-wait memory. Every transaction is followed by a mandatory single IDLE turnaround cycle.
- Streak counter:
  - Increments on each DM grant made while if_req is pending.
  - Clears on any IF grant, or on any DM grant made while if_req=0.
  - Saturates at MAX_DM_STREAK.
- Addresses pass through unmodified; the memory handles alignment.
- stall_if and stall_mem are combinational from registered acks and input reqs.
- acc_err is meaningful only while an ack is high; otherwise it is 0.

Decomposition:
- Package mips_mem_pkg holds:
  - the state enum (IDLE, IF_ACC, DM_ACC);
  - an access-descriptor struct {we, addr, wdata};
  - default constants for MAX_DM_STREAK and TIMEOUT.
- One sub-module, mem_arb_watchdog: the timeout counter with clear/enable inputs and an expire output.
- The FSM and streak logic stay in the top.

Test Plan:
- Reset, then if_req with if_addr=0x00400000, memory returning 0x8C820004 with zero wait states → mem_req high in cycle 1, if_ack high in cycle 2 with if_rdata=0x8C820004; stall_if high in cycles 0–1.
- Simultaneous if_req and dm_req, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF → store granted first with mem_we=1; dm_ack at cycle 2; fetch granted after one IDLE cycle, if_ack at cycle 5.
- dm_req held continuously, each access re-requested, with if_req pending → exactly 4 DM grants, then the 5th grant goes to IF; streak counter cleared.
- mem_ready held low for 64 cycles on a load → mem_req drops; dm_ack=1 with acc_err=1 and dm_rdata=0; the next transaction proceeds normally.
- mem_ready asserted on the same cycle the counter expires → normal completion with acc_err=0 and data captured.
- rst asserted mid-access (cycle 3 of a 10-wait access) → all outputs 0 immediately; no ack after rst drops; a fresh request is serviced normally.
